// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops, WIDTH-cycle shift-add multiply.
// Results and flags are registered and held between done pulses.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [2:0]       op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } opType;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } stateType;

  stateType         state, stateNext;
  logic [WIDTH-1:0] opA, opB, prodHi;
  logic [2:0]       opCode;
  logic [SHW-1:0]   cnt;

  logic [WIDTH-1:0] aluAns;
  logic             aluCarry, aluOvf;
  logic [WIDTH:0]   wide;
  logic [SHW-1:0]   shamt;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi, mulLo;
  logic             mulLast;

  assign ready   = (state == IDLE);
  assign done    = (state == DONE);
  assign shamt   = inB[SHW-1:0];
  assign mulLast = (cnt == SHW'(WIDTH - 1));

  // Single-cycle ops are evaluated straight from the ports so ans loads on the accept edge.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    aluAns   = '0;
    aluCarry = 1'b0;
    aluOvf   = 1'b0;
    wide     = '0;
    case (op)
      OP_AND: aluAns = inA & inB;
      OP_OR:  aluAns = inA | inB;
      OP_XOR: aluAns = inA ^ inB;
      OP_ADD: begin
        wide     = {1'b0, inA} + {1'b0, inB};
        aluAns   = wide[WIDTH-1:0];
        aluCarry = wide[WIDTH];
        aluOvf   = (inA[WIDTH-1] == inB[WIDTH-1]) && (aluAns[WIDTH-1] != inA[WIDTH-1]);
      end
      OP_SUB: begin
        wide     = {1'b0, inA} - {1'b0, inB};
        aluAns   = wide[WIDTH-1:0];
        aluCarry = wide[WIDTH];
        aluOvf   = (inA[WIDTH-1] != inB[WIDTH-1]) && (aluAns[WIDTH-1] != inA[WIDTH-1]);
      end
      OP_SLL: aluAns = inA << shamt;
      OP_SRL: aluAns = inA >> shamt;
      default: ;
    endcase
  end

  // One shift-add step: {prodHi, opB} shifts right, opB doubles as the multiplier / product low half.
  always_comb begin
    mulSum = {1'b0, prodHi} + ((opB[0] && (opCode == OP_MUL)) ? {1'b0, opA} : '0);
    mulHi  = mulSum[WIDTH:1];
    mulLo  = {mulSum[0], opB[WIDTH-1:1]};
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = (op == OP_MUL) ? MUL : DONE;
      MUL:     if (mulLast) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opA    <= '0;
      opB    <= '0;
      opCode <= '0;
      prodHi <= '0;
      cnt    <= '0;
      ans    <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opA    <= inA;
          opB    <= inB;
          opCode <= op;
          prodHi <= '0;
          cnt    <= '0;
          if (op != OP_MUL) begin
            ans   <= aluAns;
            zero  <= (aluAns == '0);
            carry <= aluCarry;
            ovf   <= aluOvf;
          end
        end
        MUL: begin
          prodHi <= mulHi;
          opB    <= mulLo;
          cnt    <= cnt + 1'b1;
          if (mulLast) begin
            ans   <= mulLo;
            zero  <= (mulLo == '0);
            carry <= |mulHi;
            ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=4): directed cases plus random ops
// compared against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] inA, inB;
  logic [2:0]   op;
  logic         ready, done, zero, carry, ovf;
  logic [W-1:0] ans;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [W-1:0] ans;
    logic         zero;
    logic         carry;
    logic         ovf;
  } resultType;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .inA(inA), .inB(inB), .op(op),
    .ready(ready), .done(done), .ans(ans), .zero(zero), .carry(carry), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    assert (obs === expv)
    else begin
      nFails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic resultType model(input int o, input int a, input int b);
    resultType r;
    int m, sa, sb, s, ss, res, sh;
    logic c, v;
    m   = 1 << W;
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    sh  = b % W;
    c   = 1'b0;
    v   = 1'b0;
    res = 0;
    case (o)
      0: res = a & b;
      1: res = a | b;
      2: res = a ^ b;
      3: begin
        s = a + b; res = s % m; c = (s >= m);
        ss = sa + sb; v = (ss >= m / 2) || (ss < -m / 2);
      end
      4: begin
        res = (a - b + m) % m; c = (a < b);
        ss = sa - sb; v = (ss >= m / 2) || (ss < -m / 2);
      end
      5: res = (a << sh) % m;
      6: res = a >> sh;
      default: begin
        s = a * b; res = s % m; c = (s >= m);
      end
    endcase
    r.ans   = res[W-1:0];
    r.zero  = (res == 0);
    r.carry = c;
    r.ovf   = v;
    return r;
  endfunction

  // Issue one op from a negedge with ready=1; scrambles the inputs right after the accept edge.
  task automatic doOp(input int o, input int a, input int b, input string tag);
    resultType e;
    int lat, gotLat;
    e   = model(o, a, b);
    lat = (o == 7) ? W + 1 : 1;
    check({tag, " ready before"}, ready, 1);
    start = 1'b1; op = 3'(o); inA = W'(a); inB = W'(b);
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); inA = W'($urandom); inB = W'($urandom);
    gotLat = 0;
    for (int k = 1; k <= lat + 4; k++) begin
      @(negedge clk);
      if (o == 7) check({tag, " ready busy"}, ready, 0);
      if (done) begin
        gotLat = k;
        break;
      end
    end
    check({tag, " latency"}, gotLat, lat);
    check({tag, " ready at done"}, ready, 0);
    check({tag, " ans"}, ans, e.ans);
    check({tag, " zero"}, zero, e.zero);
    check({tag, " carry"}, carry, e.carry);
    check({tag, " ovf"}, ovf, e.ovf);
    @(negedge clk);
    check({tag, " ready after"}, ready, 1);
    check({tag, " done after"}, done, 0);
    check({tag, " ans held"}, ans, e.ans);
  endtask

  initial begin : stim
    int doneCount, doneAt;
    logic [W-1:0] ansAtDone;
    logic         carryAtDone;

    reset_n = 1'b0; start = 1'b0; inA = '0; inB = '0; op = '0;
    #3;
    check("reset ready", ready, 1);
    check("reset done", done, 0);
    check("reset ans", ans, 0);
    check("reset flags", {zero, carry, ovf}, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Accept on the first rising edge after reset release.
    doOp(0, 'hC, 'hA, "and C&A");
    doOp(3, 'h9, 'h8, "add 9+8");
    doOp(4, 'h3, 'h5, "sub 3-5");
    doOp(4, 'h5, 'h5, "sub 5-5");
    doOp(7, 'h7, 'h3, "mul 7*3");
    doOp(5, 'h5, 'h6, "sll 5<<2");
    doOp(6, 'hD, 'h3, "srl D>>3");

    // A start during MUL must be ignored, not queued.
    start = 1'b1; op = 3'd7; inA = W'('h5); inB = W'('h6);
    @(posedge clk); #1;
    start = 1'b0;
    doneCount = 0; doneAt = 0; ansAtDone = '0; carryAtDone = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        doneCount++;
        doneAt = k;
        ansAtDone = ans;
        carryAtDone = carry;
      end
      if (k == 2) begin
        start = 1'b1; op = 3'd3; inA = W'(1); inB = W'(1);
      end
      if (k == 4) start = 1'b0;
    end
    check("ignored start done count", doneCount, 1);
    check("ignored start done cycle", doneAt, W + 1);
    check("ignored start mul ans", ansAtDone, 'hE);
    check("ignored start mul carry", carryAtDone, 1);
    check("ignored start ans held", ans, 'hE);
    check("ignored start ready", ready, 1);

    // Asynchronous reset in the middle of a multiply.
    start = 1'b1; op = 3'd7; inA = W'('h7); inB = W'('h3);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid-mul reset ready", ready, 1);
    check("mid-mul reset ans", ans, 0);
    check("mid-mul reset done", done, 0);
    check("mid-mul reset flags", {zero, carry, ovf}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    doneCount = 0;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    check("no done after reset", doneCount, 0);
    doOp(5, 'h3, 'h2, "sll 3<<2 after reset");

    // Random back-to-back ops against the model.
    for (int i = 0; i < 40; i++) begin
      doOp(int'($urandom_range(0, 7)), int'($urandom_range(0, (1 << W) - 1)),
           int'($urandom_range(0, (1 << W) - 1)), $sformatf("rand %0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width; legal values are powers of two, 4 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only while ready=1.
REQ-005 The block SHALL have port inA, input, WIDTH bits: operand A, unsigned or two's complement.
REQ-006 The block SHALL have port inB, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port op, input, 3 bits: opcode.
- 000 AND; 001 OR; 010 XOR; 011 ADD.
- 100 SUB; 101 SLL; 110 SRL; 111 MUL.
REQ-008 The block SHALL have port ready, output, 1 bit: the block is idle and accepts start.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the cycle in which ans and flags are updated.
REQ-010 The block SHALL have port ans, output, WIDTH bits: registered result.
REQ-011 The block SHALL have ports zero, carry and ovf, outputs, 1 bit each: registered result flags.

Function
REQ-012 The block SHALL use a state machine with states IDLE, MUL and DONE.
- ready=1 only in IDLE.
- done=1 only in DONE.
REQ-013 On the edge at which IDLE and start=1, the block SHALL capture inA, inB and op into internal registers (the accept edge).
- Input changes after the accept edge SHALL NOT affect the operation.
REQ-014 For op 000 to 110, the block SHALL move IDLE to DONE at the accept edge, loading ans and flags at that edge, so done=1 in the cycle after accept (latency 1).
REQ-015 For op 111, the block SHALL move IDLE to MUL at the accept edge.
- MUL runs exactly WIDTH cycles of shift-add, one multiplier bit per cycle.
- It then moves to DONE, loading ans and flags; done=1 WIDTH+1 cycles after accept.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE, so back-to-back single-cycle ops issue every 2 cycles.
REQ-017 start while ready=0 SHALL be ignored and not queued.
REQ-018 ans and flags SHALL hold their values from one DONE until the next DONE.
REQ-019 All arithmetic results SHALL be truncated to WIDTH bits.
- ADD: ans=A+B; carry=carry-out; ovf=signed overflow.
- SUB: ans=A-B; carry=1 iff A<B unsigned (borrow); ovf=signed overflow.
REQ-020 Shift amount SHALL be inB[log2(WIDTH)-1:0].
- SLL and SRL are logical, zero-filled.
- carry=0, ovf=0.
REQ-021 MUL is unsigned: ans=low WIDTH bits of A*B; carry=1 iff the high WIDTH bits of the product are nonzero; ovf=0.
REQ-022 For AND/OR/XOR, carry=0 and ovf=0.
REQ-023 For all ops, zero SHALL be set iff the new ans is 0.

Reset
REQ-024 reset_n=0 SHALL immediately, without waiting for clk, force:
- state IDLE, ready=1, done=0;
- ans=0, zero=0, carry=0, ovf=0;
- internal operand registers and MUL iteration counter to 0.
REQ-025 Reset asserted during MUL or DONE SHALL abort the operation with no done pulse.
REQ-026 The first accept SHALL be possible on the first rising clk edge after reset_n deasserts.

Verification (WIDTH=4)
REQ-027 The bench SHALL apply op=000, A=0xC, B=0xA, start=1 and check done at cycle+1 with ans=0x8, zero=0, carry=0, ovf=0.
REQ-028 The bench SHALL apply ADD A=0x9, B=0x8 and check ans=0x1, carry=1, ovf=1; then SUB A=0x3, B=0x5 and check ans=0xE, carry=1, ovf=0; then SUB A=0x5, B=0x5 and check ans=0x0, zero=1.
REQ-029 The bench SHALL apply MUL A=0x7, B=0x3 and check:
- ready=0 for cycles 1 to 5 after accept;
- done only at cycle 5, with ans=0x5, carry=1;
- ready=1 at cycle 6.
REQ-030 The bench SHALL assert start with ADD 1+1 during MUL and check that it is ignored: only one done pulse, result from MUL, and ans unchanged afterwards.
REQ-031 The bench SHALL pull reset_n low mid-MUL, off a clock edge, and check that ready=1 and ans=0 immediately and that no done follows; after release, SLL A=0x3, B=0x2 SHALL give ans=0xC.
